// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 serial transmitter fed by a small byte FIFO.
//   Decouples CPU stores to the UART data word from the line rate.
//
// Parameters
//   CLK_FREQ_HZ : system clock frequency
//   BAUD_RATE   : line rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (>= 2)
//   FIFO_DEPTH  : byte entries, power of two, >= 2
//
// Ports
//   clk        : system clock, rising edge
//   resetn     : synchronous active-low reset (aborts any frame in flight)
//   wr_stb     : one-cycle store strobe
//   wr_data    : byte to queue
//   tx         : serial line, idle high, registered
//   busy       : FIFO full; a write now would be dropped
//   idle       : FIFO empty and shifter idle
//   overflow   : sticky flag, a write arrived while busy
//   fifo_level : entries currently held
module uart_tx_fifo #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          wr_stb,
  input  logic [7:0]                    wr_data,
  output logic                          tx,
  output logic                          busy,
  output logic                          idle,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   baud_cnt;
  logic [CW-1:0]   baud_nxt;
  logic [2:0]      bit_idx;
  logic [2:0]      bit_nxt;
  logic [7:0]      shift;
  logic [7:0]      shift_nxt;
  logic            tx_nxt;
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [7:0]      head;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            baud_end;

  // Pointers carry one extra wrap bit: equal low bits with differing wrap bits means full.
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign push       = wr_stb && !full;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign baud_end   = (baud_cnt == BAUD_LAST);
  assign busy       = full;
  assign idle       = (state == S_IDLE) && empty;
  assign fifo_level = wr_ptr - rd_ptr;

  // Next-state, pop and line-value decode for the transmit FSM.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    pop       = 1'b0;
    tx_nxt    = 1'b1;
    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = head;
          baud_nxt  = '0;
          state_nxt = S_START;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_START: begin
        tx_nxt = 1'b0;
        if (baud_end) begin
          baud_nxt  = '0;
          bit_nxt   = 3'd0;
          state_nxt = S_DATA;
        end else begin
          baud_nxt = baud_cnt + CW'(1);
        end
      end
      S_DATA: begin
        tx_nxt = shift[0];
        if (baud_end) begin
          baud_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = S_STOP;
          end else begin
            shift_nxt = {1'b0, shift[7:1]};
            bit_nxt   = bit_idx + 3'd1;
          end
        end else begin
          baud_nxt = baud_cnt + CW'(1);
        end
      end
      S_STOP: begin
        tx_nxt = 1'b1;
        if (baud_end) begin
          baud_nxt = '0;
          // Chain straight into the next start bit when a byte is waiting.
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = head;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          baud_nxt = baud_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        baud_nxt  = '0;
        bit_nxt   = 3'd0;
      end
    endcase
  end

  // State, pointers, sticky overflow and the registered line output.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'h00;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      shift    <= shift_nxt;
      tx       <= tx_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (wr_stb && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo at 10 clocks per bit, depth 4.
//   A transaction-level model records each accepted byte with the edge it was
//   accepted and the edge it leaves the FIFO; every line value and status flag
//   is derived from that list. Directed scenarios add hand-computed checks.
module tb_uart_tx_fifo;

  localparam int CPB   = 10;   // 1000 Hz / 100 baud
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       resetn;
  logic       wr_stb;
  logic [7:0] wr_data;
  logic       tx;
  logic       busy;
  logic       idle;
  logic       overflow;
  logic [2:0] fifo_level;

  int checks   = 0;
  int failures = 0;

  uart_tx_fifo #(
    .CLK_FREQ_HZ(1000),
    .BAUD_RATE  (100),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .wr_stb    (wr_stb),
    .wr_data   (wr_data),
    .tx        (tx),
    .busy      (busy),
    .idle      (idle),
    .overflow  (overflow),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  typedef struct {
    int         acc;
    int         pop;
    logic [7:0] data;
  } ent_t;

  ent_t q[$];
  int   cyc      = 0;
  bit   model_ok = 1'b0;
  logic m_ovf    = 1'b0;
  int   last_pop = -100000;

  function automatic int level_at(input int e);
    int n = 0;
    foreach (q[i]) begin
      if (q[i].acc <= e && q[i].pop > e) n++;
    end
    return n;
  endfunction

  function automatic logic tx_at(input int e);
    logic v = 1'b1;
    int   k;
    foreach (q[i]) begin
      if (e >= q[i].pop + 1 && e <= q[i].pop + FRAME) begin
        k = (e - q[i].pop - 1) / CPB;
        if (k == 0)      v = 1'b0;
        else if (k == 9) v = 1'b1;
        else             v = q[i].data[k-1];
      end
    end
    return v;
  endfunction

  function automatic logic idle_at(input int e);
    logic sending = 1'b0;
    foreach (q[i]) begin
      if (e >= q[i].pop && e < q[i].pop + FRAME) sending = 1'b1;
    end
    return !sending && (level_at(e) == 0);
  endfunction

  // Model update on every rising edge, from the same inputs the DUT samples.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!resetn) begin
      q.delete();
      m_ovf    = 1'b0;
      last_pop = -100000;
      model_ok = 1'b1;
    end else if (wr_stb) begin
      if (level_at(cyc - 1) == DEPTH) begin
        m_ovf = 1'b1;
      end else begin : accept
        int p;
        p = (cyc + 1 > last_pop + FRAME) ? cyc + 1 : last_pop + FRAME;
        q.push_back('{acc: cyc, pop: p, data: wr_data});
        last_pop = p;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      chk($sformatf("tx@%0d", cyc),       32'(tx),         32'(tx_at(cyc)));
      chk($sformatf("busy@%0d", cyc),     32'(busy),       32'(level_at(cyc) == DEPTH));
      chk($sformatf("idle@%0d", cyc),     32'(idle),       32'(idle_at(cyc)));
      chk($sformatf("overflow@%0d", cyc), 32'(overflow),   32'(m_ovf));
      chk($sformatf("level@%0d", cyc),    32'(fifo_level), 32'(level_at(cyc)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic write_byte(input logic [7:0] b);
    wr_data = b;
    wr_stb  = 1'b1;
    @(negedge clk);
    wr_stb  = 1'b0;
  endtask

  // Called right after write_byte into an idle DUT; bits[k] is the k-th line bit.
  task automatic frame_check(input string name, input logic [9:0] bits);
    @(negedge clk);
    chk({name, "_pre_start"}, 32'(tx), 32'd1);
    @(negedge clk);
    chk({name, "_start_edge"}, 32'(tx), 32'd0);
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? 5 : CPB) @(negedge clk);
      chk($sformatf("%s_bit%0d", name, k), 32'(tx), 32'(bits[k]));
    end
    repeat (3) @(negedge clk);
    chk({name, "_idle_before_end"}, 32'(idle), 32'd0);
    @(negedge clk);
    chk({name, "_idle_after_end"}, 32'(idle), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (idle !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_wait_idle"}, 32'(idle), 32'd1);
  endtask

  task automatic wait_not_busy(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_wait_not_busy"}, 32'(busy), 32'd0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [9:0] bits_41;
    logic [9:0] bits_7e;
    logic [7:0] burst [6];
    bits_41  = 10'b10_1000_0010;  // start, 0x41 LSB first, stop
    bits_7e  = 10'b10_1111_1100;  // start, 0x7E LSB first, stop
    burst[0] = 8'h55; burst[1] = 8'hAA; burst[2] = 8'h0F;
    burst[3] = 8'hF0; burst[4] = 8'h3C; burst[5] = 8'hC3;

    resetn  = 1'b0;
    wr_stb  = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx",       32'(tx),         32'd1);
    chk("rst_idle",     32'(idle),       32'd1);
    chk("rst_busy",     32'(busy),       32'd0);
    chk("rst_overflow", 32'(overflow),   32'd0);
    chk("rst_level",    32'(fifo_level), 32'd0);
    resetn = 1'b1;

    // Quiet line after reset.
    repeat (50) @(negedge clk);
    chk("quiet_tx",   32'(tx),   32'd1);
    chk("quiet_idle", 32'(idle), 32'd1);

    // Single byte 0x41.
    write_byte(8'h41);
    chk("single_idle_drop", 32'(idle), 32'd0);
    frame_check("single41", bits_41);

    // Burst of five on consecutive cycles: one popped, four buffered, no drop.
    for (int i = 0; i < 5; i++) begin
      wr_data = burst[i];
      wr_stb  = 1'b1;
      @(negedge clk);
    end
    wr_stb = 1'b0;
    chk("burst_busy",     32'(busy),       32'd1);
    chk("burst_level",    32'(fifo_level), 32'd4);
    chk("burst_overflow", 32'(overflow),   32'd0);
    repeat (496) @(negedge clk);
    chk("burst_idle_at_500", 32'(idle), 32'd0);
    @(negedge clk);
    chk("burst_idle_at_501", 32'(idle), 32'd1);

    // Six consecutive writes: sixth dropped, overflow sticks.
    for (int i = 0; i < 6; i++) begin
      wr_data = burst[5 - i];
      wr_stb  = 1'b1;
      @(negedge clk);
    end
    wr_stb = 1'b0;
    chk("ovf_flag",  32'(overflow),   32'd1);
    chk("ovf_level", 32'(fifo_level), 32'd4);
    wait_idle("ovf");
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Twelve bytes, each issued only when not busy; pointers wrap repeatedly.
    for (int i = 0; i < 12; i++) begin
      wait_not_busy($sformatf("wrap%0d", i));
      write_byte(8'(8'h10 + 8'(i * 17)));
    end
    wait_idle("wrap");
    chk("wrap_level", 32'(fifo_level), 32'd0);

    // Reset during the data bits of 0x00, then a clean 0x7E frame.
    write_byte(8'h00);
    repeat (40) @(negedge clk);
    chk("midrst_in_frame", 32'(idle), 32'd0);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("midrst_tx",       32'(tx),         32'd1);
    chk("midrst_idle",     32'(idle),       32'd1);
    chk("midrst_level",    32'(fifo_level), 32'd0);
    chk("midrst_overflow", 32'(overflow),   32'd0);
    write_byte(8'h7E);
    frame_check("post_rst7e", bits_7e);

    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if the run stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
